norm_scaler_mc: RTL and testbench
=================================

Name: norm_scaler_mc

Overview:
- Multi-lane, parametrised successor to the single-pixel normaliser.
- Multiplies every pixel of a post-crop streamed frame by 1/norm_den and streams the result downstream with a frame tlast.
- The reciprocal is computed at frame start by an iterative divider, not a LUT, so any PIX_W is supported.
- Frame size is runtime-programmable. Sits between the crop stage and the inference core under ap_start/ap_done control.

Parameters:
- PIX_W, 8, bits per pixel.
- LANES, 4, pixels per AXIS beat (lane 0 in LSBs).
- FRAC_W, 24, fractional bits of the reciprocal; coefficient width is FRAC_W+1.
- MAX_PIX, 4096, maximum pixels per frame.
- FIFO_DEPTH, 16, output FIFO depth in beats (power of 2, at least 4).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- ap_start, in, 1, start request; accepted only in IDLE.
- ap_ready, out, 1, high in IDLE.
- ap_idle, out, 1, high in IDLE with the FIFO empty.
- ap_done, out, 1, one-cycle pulse when the final output beat is accepted.
- frame_pixels, in, clog2(MAX_PIX+1), pixels this frame; latched on ap_start.
- norm_den, in, PIX_W, denominator; latched on ap_start.
- s_axis_tvalid, in, 1, input beat valid.
- s_axis_tready, out, 1, input beat ready.
- s_axis_tdata, in, LANES*PIX_W, input pixels.
- s_axis_tlast, in, 1, upstream end-of-frame; checked only.
- m_axis_tvalid, out, 1, output beat valid.
- m_axis_tready, in, 1, output beat ready.
- m_axis_tdata, out, LANES*PIX_W, normalised pixels.
- m_axis_tlast, out, 1, high on the last beat of the frame.
- err_den_zero, out, 1, sticky; cleared on reset or the next accepted ap_start.
- err_tlast, out, 1, sticky; same clearing rule as err_den_zero.

Behaviour:
- Reset values: FSM=IDLE, FIFO flushed.
  - ap_ready=1, ap_idle=1.
  - ap_done=0, s_axis_tready=0.
  - m_axis_tvalid=0, m_axis_tlast=0.
  - Both error flags 0, all counters 0.
- Reset mid-frame aborts immediately: in-flight data is discarded and no ap_done is issued.
- frame_pixels rules:
  - Must be a multiple of LANES; the low bits are ignored.
  - Values above MAX_PIX are clamped to MAX_PIX.
  - Beats per frame: total_beats = frame_pixels/LANES.
- FSM states: IDLE, RECIP, STREAM, DRAIN.
- IDLE -> RECIP:
  - Taken on ap_start=1; frame_pixels and norm_den are latched.
  - ap_start in any other state is ignored.
- RECIP (exactly FRAC_W+1 cycles):
  - Restoring division computes coef = floor(2^FRAC_W / den), one quotient bit per cycle, MSB first.
  - den=0: coef forced to 2^FRAC_W (unity pass-through) and err_den_zero set.
  - den=1: coef = 2^FRAC_W exactly.
- RECIP -> STREAM: after the last quotient bit. If total_beats=0, go straight to IDLE and pulse ap_done in the same cycle.
- STREAM:
  - s_axis_tready = (beats_in < total_beats) AND (fifo_count + inflight <= FIFO_DEPTH-1), where inflight counts beats in the pipeline.
  - tready does not depend on s_axis_tvalid.
  - Goes to DRAIN once beats_in reaches total_beats.
- Arithmetic, per lane:
  - prod = pix * coef, width PIX_W+FRAC_W+1.
  - out = (prod + 2^(FRAC_W-1)) >> FRAC_W, i.e. round half up.
  - out saturates to 2^PIX_W-1.
- Pipeline: 2 register stages (product, then round/saturate), then the FIFO.
  - Input acceptance to m_axis_tvalid = 3 cycles with the FIFO empty.
  - The pipeline never stalls; backpressure acts only via the credit check on tready.
- m_axis_tlast travels with the data and is set on beat total_beats-1.
- err_tlast is set if s_axis_tlast=1 on a non-final beat, or 0 on the final beat. Framing always follows the beat count, never s_axis_tlast.
- DRAIN:
  - Waits until the tlast beat is accepted (m_axis_tvalid & m_axis_tready & m_axis_tlast).
  - Then pulses ap_done for 1 cycle and returns to IDLE in the same edge.
- AXIS rules:
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
  - No beat is lost or duplicated under any tready pattern.
  - A FIFO push and pop in the same cycle while full or empty are handled without overflow or bubble.

Test Plan:
- LANES=4, den=4, frame_pixels=16, pixels {200,100,4,0} repeated, m_axis_tready=1 -> 4 output beats {50,25,1,0}; tlast on beat 4; one ap_done pulse; first s_axis_tready 25 cycles after ap_start accepted.
- den=3, pixel 255 -> 85 (coef 5592405). den=7, pixel 7 -> 1 (checks rounding). den=1, pixel 255 -> 255, no overflow.
- den=0, pixel 123 -> 123 passed through; err_den_zero=1 until the next ap_start.
- frame_pixels=64, random s_axis_tvalid, m_axis_tready at 30% duty -> all 16 beats in order, no loss or duplication; FIFO count never exceeds 16; tdata stable while stalled.
- s_axis_tlast asserted on beat 2 of 4 -> err_tlast=1; output still 4 beats with tlast on beat 4.
- reset asserted mid-STREAM -> next cycle: m_axis_tvalid=0, ap_ready=1, no ap_done. A following frame with den=2 produces correct output.

Source files
------------

// File: rtl/norm_scaler_mc_if.sv
// AXI4-Stream style beat channel shared by the scaler's input and output ports.
// master drives the beat, slave returns the ready.
interface norm_scaler_mc_if #(
  parameter int DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/norm_scaler_mc.sv
// Multi-lane frame normaliser: scales every pixel by 1/norm_den using a reciprocal
// computed at frame start by a restoring divider, under ap_start/ap_done control.
module norm_scaler_mc #(
  parameter int PIX_W      = 8,
  parameter int LANES      = 4,
  parameter int FRAC_W     = 24,
  parameter int MAX_PIX    = 4096,
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W     = $clog2(MAX_PIX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_idle,
  output logic             ap_done,
  input  logic [CNT_W-1:0] frame_pixels,
  input  logic [PIX_W-1:0] norm_den,
  norm_scaler_mc_if.slave  s_axis,
  norm_scaler_mc_if.master m_axis,
  output logic             err_den_zero,
  output logic             err_tlast
);
  localparam int COEF_W = FRAC_W + 1;
  localparam int PROD_W = PIX_W + FRAC_W + 1;
  localparam int DATA_W = LANES * PIX_W;
  localparam int BEAT_W = $clog2(MAX_PIX / LANES + 1);
  localparam int RC_W   = $clog2(FRAC_W + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int FC_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [COEF_W-1:0] COEF_ONE = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [PROD_W-1:0] HALF     = {{(PROD_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  MAX_C    = CNT_W'(MAX_PIX);
  localparam logic [CNT_W-1:0]  LANES_C  = CNT_W'(LANES);
  localparam logic [FC_W:0]     CREDIT   = (FC_W+1)'(FIFO_DEPTH - 1);
  localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(FRAC_W);

  typedef enum logic [1:0] {IDLE = 2'd0, RECIP = 2'd1, STREAM = 2'd2, DRAIN = 2'd3} state_t;
  state_t state, state_nx;
  logic   done_nx;

  logic [PIX_W-1:0]  den;
  logic [BEAT_W-1:0] total_beats, beats_in;
  logic [RC_W-1:0]   rcnt;
  logic [PIX_W:0]    rem, rem_sh, rem_nx;
  logic [COEF_W-1:0] quo, quo_nx, coef;
  logic              ge, recip_last;

  logic              p1_valid, p1_last, p2_valid, p2_last;
  logic [PROD_W-1:0] p1_prod [LANES];
  logic [DATA_W-1:0] p2_data_nx, p2_data;

  logic [DATA_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [FC_W-1:0]   fifo_count;
  logic [FC_W:0]     used;
  logic [CNT_W-1:0]  fp_clamp;
  logic              s_ready, accept, in_last, m_valid, push, pop;

  // Dividend is 2^FRAC_W, so only the first shifted-in bit is a one.
  assign rem_sh     = {rem[PIX_W-1:0], (rcnt == {RC_W{1'b0}})};
  assign ge         = (rem_sh >= {1'b0, den});
  assign rem_nx     = ge ? (rem_sh - {1'b0, den}) : rem_sh;
  assign quo_nx     = {quo[COEF_W-2:0], ge};
  assign recip_last = (rcnt == RC_LAST);

  assign fp_clamp = (frame_pixels > MAX_C) ? MAX_C : frame_pixels;
  assign used     = {1'b0, fifo_count} + {{FC_W{1'b0}}, p1_valid} + {{FC_W{1'b0}}, p2_valid};
  assign s_ready  = (state == STREAM) && (beats_in < total_beats) && (used <= CREDIT);
  assign accept   = s_ready & s_axis.tvalid;
  assign in_last  = (beats_in == (total_beats - {{(BEAT_W-1){1'b0}}, 1'b1}));
  assign m_valid  = (fifo_count != {FC_W{1'b0}});
  assign push     = p2_valid;
  assign pop      = m_valid & m_axis.tready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = mem[rd_ptr][DATA_W-1:0];
  assign m_axis.tlast  = m_valid & mem[rd_ptr][DATA_W];
  assign ap_ready      = (state == IDLE);
  assign ap_idle       = (state == IDLE) && !m_valid;

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) state_nx = RECIP;
        else          state_nx = IDLE;
      end
      RECIP: begin
        if (recip_last) begin
          if (total_beats == {BEAT_W{1'b0}}) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx = STREAM;
          end
        end else begin
          state_nx = RECIP;
        end
      end
      STREAM: begin
        if (beats_in == total_beats) state_nx = DRAIN;
        else                         state_nx = STREAM;
      end
      DRAIN: begin
        if (pop && m_axis.tlast) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ap_done      <= 1'b0;
      den          <= {PIX_W{1'b0}};
      total_beats  <= {BEAT_W{1'b0}};
      beats_in     <= {BEAT_W{1'b0}};
      rcnt         <= {RC_W{1'b0}};
      rem          <= {(PIX_W+1){1'b0}};
      quo          <= {COEF_W{1'b0}};
      coef         <= {COEF_W{1'b0}};
      err_den_zero <= 1'b0;
      err_tlast    <= 1'b0;
    end else begin
      state   <= state_nx;
      ap_done <= done_nx;
      if ((state == IDLE) && ap_start) begin
        den          <= norm_den;
        total_beats  <= BEAT_W'(fp_clamp / LANES_C);
        beats_in     <= {BEAT_W{1'b0}};
        rcnt         <= {RC_W{1'b0}};
        rem          <= {(PIX_W+1){1'b0}};
        quo          <= {COEF_W{1'b0}};
        err_den_zero <= (norm_den == {PIX_W{1'b0}});
        err_tlast    <= 1'b0;
      end else if (state == RECIP) begin
        rcnt <= rcnt + {{(RC_W-1){1'b0}}, 1'b1};
        rem  <= rem_nx;
        quo  <= quo_nx;
        if (recip_last) coef <= (den == {PIX_W{1'b0}}) ? COEF_ONE : quo_nx;
      end
      if (accept) begin
        beats_in <= beats_in + {{(BEAT_W-1){1'b0}}, 1'b1};
        if (s_axis.tlast != in_last) err_tlast <= 1'b1;
      end
    end
  end

  // Round half up, then clamp anything that reaches 2^PIX_W.
  always_comb begin
    p2_data_nx = {DATA_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      logic [PROD_W-1:0] rsum;
      rsum = p1_prod[i] + HALF;
      if (rsum[PROD_W-1]) p2_data_nx[i*PIX_W +: PIX_W] = {PIX_W{1'b1}};
      else                p2_data_nx[i*PIX_W +: PIX_W] = rsum[PROD_W-2:FRAC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_last  <= 1'b0;
      p2_valid <= 1'b0;
      p2_last  <= 1'b0;
      p2_data  <= {DATA_W{1'b0}};
      for (int i = 0; i < LANES; i++) p1_prod[i] <= {PROD_W{1'b0}};
    end else begin
      p1_valid <= accept;
      p2_valid <= p1_valid;
      p2_last  <= p1_last;
      p2_data  <= p2_data_nx;
      if (accept) begin
        p1_last <= in_last;
        for (int i = 0; i < LANES; i++)
          p1_prod[i] <= {{(PROD_W-PIX_W){1'b0}}, s_axis.tdata[i*PIX_W +: PIX_W]}
                      * {{(PROD_W-COEF_W){1'b0}}, coef};
      end
    end
  end

  // The credit check on s_ready guarantees a push never lands on a full FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= {AW{1'b0}};
      rd_ptr     <= {AW{1'b0}};
      fifo_count <= {FC_W{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + {{(FC_W-1){1'b0}}, 1'b1};
        2'b01:   fifo_count <= fifo_count - {{(FC_W-1){1'b0}}, 1'b1};
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {p2_last, p2_data};
  end
endmodule

// File: tb/tb_norm_scaler_mc.sv
// Scoreboard bench for norm_scaler_mc: expected beats are queued as input beats are
// accepted and compared in order as output beats are accepted.
module tb_norm_scaler_mc;
  localparam int LANES   = 4;
  localparam int MAX_PIX = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready, ap_idle, ap_done, err_den_zero, err_tlast;
  logic [12:0] frame_pixels = 13'd0;
  logic [7:0]  norm_den = 8'd0;

  norm_scaler_mc_if #(.DATA_W(32)) s_if ();
  norm_scaler_mc_if #(.DATA_W(32)) m_if ();

  norm_scaler_mc dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .ap_done(ap_done), .frame_pixels(frame_pixels),
    .norm_den(norm_den), .s_axis(s_if), .m_axis(m_if),
    .err_den_zero(err_den_zero), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          extra = 0;
  int          rpct = 100;
  logic [32:0] sb [$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_val = 33'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_pix(input logic [7:0] p, input int den);
    longint c, r;
    c = (den == 0) ? (64'sd1 <<< 24) : ((64'sd1 <<< 24) / longint'(den));
    r = (longint'(p) * c + (64'sd1 <<< 23)) >>> 24;
    return (r > 255) ? 8'd255 : r[7:0];
  endfunction

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'd0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_if.tready = ($urandom_range(99) < rpct);
    end
  end

  // Output monitor: ordering, hold-while-stalled and ap_done pulse count.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (ap_done) done_cnt++;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("hold", 64'({m_if.tvalid, m_if.tlast, m_if.tdata}), 64'({1'b1, prev_val}));
        if (m_if.tvalid && m_if.tready) begin
          if (sb.size() == 0) extra++;
          else begin
            e = sb.pop_front();
            chk("beat", 64'({m_if.tlast, m_if.tdata}), 64'(e));
          end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_val   = {m_if.tlast, m_if.tdata};
      end
    end
  end

  task automatic run_frame(input int den, input int fp, input logic [31:0] pat, input bit rnd,
                           input int vprob, input int rp, input int bad_beat, input int abort_at);
    int nb, b, cyc, lat, d0;
    logic [31:0] d;
    logic [32:0] e;
    nb   = ((fp > MAX_PIX) ? MAX_PIX : fp) / LANES;
    d0   = done_cnt;
    rpct = rp;
    @(posedge clk);
    #1;
    ap_start = 1'b1; frame_pixels = 13'(fp); norm_den = 8'(den);
    @(posedge clk);
    #1 ap_start = 1'b0;
    lat = 0;
    while (!s_if.tready && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("rdy_lat", 64'(lat), 64'd25);
    b = 0; cyc = 0;
    d = rnd ? $urandom : pat;
    while (b < nb && b != abort_at && cyc < 8000) begin
      s_if.tvalid = ($urandom_range(99) < vprob);
      s_if.tdata  = d;
      s_if.tlast  = (b == nb - 1) ^ (b == bad_beat);
      @(negedge clk);
      if (s_if.tvalid && s_if.tready) begin
        for (int l = 0; l < LANES; l++) e[l*8 +: 8] = ref_pix(d[l*8 +: 8], den);
        e[32] = (b == nb - 1);
        sb.push_back(e);
        b++;
        d = rnd ? $urandom : pat;
      end
      @(posedge clk);
      #1 cyc++;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    if (abort_at >= 0) begin
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_state", 64'({m_if.tvalid, ap_ready, s_if.tready}), 64'(3'b010));
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_done", 64'(done_cnt - d0), 64'd0);
      chk("abort_idle", 64'(ap_idle), 64'd1);
    end else begin
      chk("beats_in", 64'(b), 64'(nb));
      cyc = 0;
      while ((sb.size() != 0 || !ap_ready) && cyc < 4000) begin
        @(posedge clk);
        #1 cyc++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("done", 64'(done_cnt - d0), 64'd1);
      chk("err_den", 64'(err_den_zero), 64'(den == 0));
      chk("err_tlast", 64'(err_tlast), 64'(bad_beat >= 0));
      chk("idle", 64'(ap_idle), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset", 64'({ap_ready, ap_idle, ap_done, s_if.tready, m_if.tvalid, m_if.tlast,
                      err_den_zero, err_tlast}), 64'(8'b1100_0000));
    @(posedge clk);
    #1 reset = 1'b0;
    run_frame(4, 16, {8'd0, 8'd4, 8'd100, 8'd200}, 1'b0, 100, 100, -1, -1);
    run_frame(3, 4, {4{8'd255}}, 1'b0, 100, 100, -1, -1);
    run_frame(7, 4, {4{8'd7}}, 1'b0, 100, 100, -1, -1);
    run_frame(1, 4, {4{8'd255}}, 1'b0, 100, 100, -1, -1);
    run_frame(0, 4, {4{8'd123}}, 1'b0, 100, 100, -1, -1);
    repeat (5) @(posedge clk);
    #1 chk("err_den_sticky", 64'(err_den_zero), 64'd1);
    run_frame(5, 64, 32'd0, 1'b1, 60, 30, -1, -1);
    run_frame(9, 16, {8'd90, 8'd45, 8'd18, 8'd9}, 1'b0, 100, 100, 1, -1);
    run_frame(6, 18, 32'd0, 1'b1, 80, 70, -1, -1);
    run_frame(5, 16, 32'd0, 1'b1, 100, 0, -1, 3);
    run_frame(2, 16, 32'd0, 1'b1, 100, 100, -1, -1);
    run_frame(11, 4100, 32'd0, 1'b1, 100, 100, -1, -1);
    chk("extra_beats", 64'(extra), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
